// File: rtl/spi_register_port.sv
// SPI slave register port (mode 0, MSB first, no chip select).
// Turns 32-bit host frames {W, number[14:0], value[15:0]} into single-cycle
// register-write strobes, and streams the newest audio sample back on MISO.
module spi_register_port #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SampleReady,
  input  logic [15:0] i_SampleToOutput,
  input  logic        i_SPI_SCK,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO,
  output logic        o_RegisterWriteEnable,
  output logic [14:0] o_RegisterWriteNumber,
  output logic [15:0] o_RegisterWriteValue
);

  localparam int             CW       = $clog2(FRAME_BITS);
  localparam logic [CW-1:0]  LAST_BIT = CW'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] r_SckSync;
  logic [SYNC_STAGES-1:0] r_MosiSync;
  logic                   r_SckPrev;
  logic [CW-1:0]          r_BitCnt;
  logic [FRAME_BITS-1:0]  r_Rx;
  logic [FRAME_BITS-1:0]  r_Tx;
  logic                   r_FrameDone;
  logic                   r_InitLoad;
  logic [15:0]            r_Sample;
  logic                   r_NewFlag;

  logic w_Sck, w_Mosi, w_SckRise, w_SckFall, w_Load, w_Shift;

  assign w_Sck     = r_SckSync[SYNC_STAGES-1];
  assign w_Mosi    = r_MosiSync[SYNC_STAGES-1];
  assign w_SckRise = w_Sck & ~r_SckPrev;
  assign w_SckFall = ~w_Sck & r_SckPrev;
  assign w_Load    = r_FrameDone | r_InitLoad;
  // The fall that follows the frame-completing rise (counter already wrapped
  // to 0) must not shift, otherwise the freshly loaded MSB would be lost
  // before the host samples it on the next frame's first rise.
  assign w_Shift   = w_SckFall && (r_BitCnt != '0);

  // Synchronise SCK/MOSI and keep the previous SCK level for edge detect
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_SckSync  <= '0;
      r_MosiSync <= '0;
      r_SckPrev  <= 1'b0;
    end else begin
      r_SckSync  <= {r_SckSync[SYNC_STAGES-2:0], i_SPI_SCK};
      r_MosiSync <= {r_MosiSync[SYNC_STAGES-2:0], i_SPI_MOSI};
      r_SckPrev  <= w_Sck;
    end
  end

  // Receive shift register, bit counter and frame-complete pulse
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_Rx        <= '0;
      r_BitCnt    <= '0;
      r_FrameDone <= 1'b0;
    end else begin
      if (w_SckRise) begin
        r_Rx     <= {r_Rx[FRAME_BITS-2:0], w_Mosi};
        r_BitCnt <= r_BitCnt + 1'b1;
      end
      r_FrameDone <= w_SckRise && (r_BitCnt == LAST_BIT);
    end
  end

  // Register-write strobe one clock after a completed write frame
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterWriteNumber <= '0;
      o_RegisterWriteValue  <= '0;
    end else begin
      o_RegisterWriteEnable <= r_FrameDone & r_Rx[31];
      if (r_FrameDone && r_Rx[31]) begin
        o_RegisterWriteNumber <= r_Rx[30:16];
        o_RegisterWriteValue  <= r_Rx[15:0];
      end
    end
  end

  // Latch the newest sample; the new flag clears on tx load unless a sample
  // arrives in that same cycle
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_Sample  <= '0;
      r_NewFlag <= 1'b0;
    end else begin
      if (i_SampleReady) begin
        r_Sample  <= i_SampleToOutput;
        r_NewFlag <= 1'b1;
      end else if (w_Load) begin
        r_NewFlag <= 1'b0;
      end
    end
  end

  // Transmit register: load at frame boundary (and once after reset), shift on SCK fall
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_Tx       <= '0;
      r_InitLoad <= 1'b1;
      o_SPI_MISO <= 1'b0;
    end else begin
      r_InitLoad <= 1'b0;
      if (w_Load)
        r_Tx <= {r_Sample, 15'b0, r_NewFlag};
      else if (w_Shift)
        r_Tx <= {r_Tx[FRAME_BITS-2:0], 1'b0};
      o_SPI_MISO <= r_Tx[FRAME_BITS-1];
    end
  end

endmodule

// File: tb/tb_spi_register_port.sv
// Directed bench for spi_register_port: scoreboard queues for write strobes
// and MISO words, compared with immediate assertions.
module tb_spi_register_port;

  localparam int HALF = 8;  // i_Clock periods per SCK half-period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sready = 1'b0;
  logic [15:0] sample = '0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        wen;
  logic [14:0] wnum;
  logic [15:0] wval;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [14:0] num;
    logic [15:0] val;
    int          c;
  } obs_t;

  obs_t        obs_q[$];
  logic [30:0] exp_q[$];
  int          rise_q[$];
  logic [31:0] miso_q[$];

  spi_register_port dut (
    .i_Clock               (clk),
    .i_Reset_n             (rst_n),
    .i_SampleReady         (sready),
    .i_SampleToOutput      (sample),
    .i_SPI_SCK             (sck),
    .i_SPI_MOSI            (mosi),
    .o_SPI_MISO            (miso),
    .o_RegisterWriteEnable (wen),
    .o_RegisterWriteNumber (wnum),
    .o_RegisterWriteValue  (wval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe cycle (a two-cycle pulse shows up as a stray entry)
  always @(negedge clk) if (wen) obs_q.push_back('{wnum, wval, cyc});

  initial begin
    #3ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sck = 1'b0;
    mosi = 1'b0;
    clocks(4);
    rst_n = 1'b1;
    clocks(4);
  endtask

  task automatic pulse_sample(input logic [15:0] s);
    sample = s;
    sready = 1'b1;
    clocks(1);
    sready = 1'b0;
    clocks(2);
  endtask

  // send nbits MSB-first; host samples MISO just before each rise
  task automatic send_frame(input logic [31:0] w, input int nbits);
    logic [31:0] got;
    logic [31:0] e;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[31-i];
      clocks(HALF);
      got = {got[30:0], miso};
      sck = 1'b1;
      if (i == 31 && w[31]) rise_q.push_back(cyc);
      clocks(HALF);
      sck = 1'b0;
    end
    if (nbits == 32) begin
      e = miso_q.pop_front();
      chk("miso_word", got, e);
    end
  endtask

  task automatic write_frame(input logic [31:0] w, input logic [31:0] exp_miso);
    if (w[31]) exp_q.push_back(w[30:0]);
    miso_q.push_back(exp_miso);
    send_frame(w, 32);
  endtask

  task automatic check_strobes();
    obs_t        o;
    logic [30:0] e;
    int          r;
    clocks(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rise_q.pop_front();
      chk("strobe_present", obs_q.size() > 0, 1);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        chk("strobe_num", o.num, e[30:16]);
        chk("strobe_val", o.val, e[15:0]);
        chk("strobe_latency_3to5", (o.c - r >= 3) && (o.c - r <= 5), 1);
      end
    end
    chk("stray_strobes", obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_wen", wen, 0);
    chk("rst_wnum", wnum, 0);
    chk("rst_wval", wval, 0);
    chk("rst_miso", miso, 0);

    // write frame, nothing sampled yet -> MISO zeros
    write_frame(32'h8005_1234, 32'h0000_0000);
    check_strobes();

    // read frame: no strobe, outputs hold
    write_frame(32'h0005_1234, 32'h0000_0000);
    check_strobes();
    chk("hold_num", wnum, 15'h0005);
    chk("hold_val", wval, 16'h1234);

    // new sample appears on the frame after the next boundary, flag set once
    pulse_sample(16'hBEEF);
    write_frame(32'h0000_0000, 32'h0000_0000);
    write_frame(32'h0000_0000, 32'hBEEF_0001);
    write_frame(32'h0000_0000, 32'hBEEF_0000);
    check_strobes();

    // only the newest of two samples is kept
    pulse_sample(16'h1111);
    pulse_sample(16'h2222);
    write_frame(32'h0000_0000, 32'hBEEF_0000);
    write_frame(32'h0000_0000, 32'h2222_0001);
    check_strobes();

    // partial frame aborted by reset, then a full write
    send_frame(32'hFFFF_FFFF, 10);
    do_reset();
    chk("rst2_wnum", wnum, 0);
    chk("rst2_miso", miso, 0);
    check_strobes();
    write_frame(32'h80FF_00AA, 32'h0000_0000);
    check_strobes();

    // back-to-back writes
    write_frame(32'h8001_0001, 32'h0000_0000);
    write_frame(32'h8002_0002, 32'h0000_0000);
    check_strobes();
    chk("b2b_num", wnum, 15'h0002);
    chk("b2b_val", wval, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
